// File: rtl/ex_div.sv
// Iterative restoring 32-bit divider for the EX stage: one quotient bit per cycle, result {remainder, quotient}.
// Optional build macro DIV_ZERO_DIVIDEND_EN: a zero dividend takes the one-cycle zero-result path.
`timescale 1ns/1ps
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DIV_START,
  input  logic                  DIV_SIGNED,
  input  logic [DATA_W-1:0]     DIV_OPDATA1,
  input  logic [DATA_W-1:0]     DIV_OPDATA2,
  input  logic                  DIV_ANNUL,
  output logic [2*DATA_W-1:0]   DIV_RESULT,
  output logic                  DIV_READY,
  output logic                  DIV_BUSY
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W:0]     work_q;
  logic [2*DATA_W:0]     work_d;
  logic [DATA_W-1:0]     divisor_q;
  logic                  qneg_q;
  logic                  rneg_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  ready_q;

  logic [2*DATA_W:0]     shifted;
  logic [DATA_W:0]       upper;
  logic [DATA_W+1:0]     diff;
  logic                  take_zero;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Partial remainder lives in work[63:32], quotient bits shift in at work[0].
  always_comb begin
    shifted = work_q << 1;
    upper   = shifted[2*DATA_W:DATA_W];
    diff    = {1'b0, upper} - {2'b0, divisor_q};
    work_d  = shifted;
    if (!diff[DATA_W+1]) begin
      work_d = {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
    end
  end

  always_comb begin
    take_zero = (DIV_OPDATA2 == '0);
`ifdef DIV_ZERO_DIVIDEND_EN
    take_zero = take_zero || (DIV_OPDATA1 == '0);
`else
    take_zero = take_zero;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          if (DIV_START && !DIV_ANNUL) begin
            if (take_zero) begin
              state_q <= BY_ZERO;
            end else begin
              state_q   <= ON;
              cnt_q     <= '0;
              divisor_q <= mag(DIV_OPDATA2, DIV_SIGNED);
              work_q    <= {{(DATA_W+1){1'b0}}, mag(DIV_OPDATA1, DIV_SIGNED)};
              qneg_q    <= DIV_SIGNED && (DIV_OPDATA1[DATA_W-1] ^ DIV_OPDATA2[DATA_W-1]);
              rneg_q    <= DIV_SIGNED && DIV_OPDATA1[DATA_W-1];
            end
          end
        end
        BY_ZERO: begin
          if (DIV_ANNUL) begin
            state_q <= FREE;
          end else begin
            state_q  <= END;
            result_q <= '0;
            ready_q  <= 1'b1;
          end
        end
        ON: begin
          if (DIV_ANNUL) begin
            state_q <= FREE;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            result_q <= {apply_sign(work_q[2*DATA_W-1:DATA_W], rneg_q),
                         apply_sign(work_q[DATA_W-1:0], qneg_q)};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        END: begin
          if (DIV_ANNUL || !DIV_START) begin
            state_q  <= FREE;
            result_q <= '0;
            ready_q  <= 1'b0;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  assign DIV_RESULT = result_q;
  assign DIV_READY  = ready_q;
  assign DIV_BUSY   = (state_q != FREE);

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, signed/unsigned results, divide-by-zero, annul and reset aborts.
`timescale 1ns/1ps
module tb_ex_div;

  logic        CLK = 1'b0;
  logic        RST;
  logic        DIV_START;
  logic        DIV_SIGNED;
  logic [31:0] DIV_OPDATA1;
  logic [31:0] DIV_OPDATA2;
  logic        DIV_ANNUL;
  logic [63:0] DIV_RESULT;
  logic        DIV_READY;
  logic        DIV_BUSY;

  int checks = 0;
  int errors = 0;

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .CLK(CLK), .RST(RST), .DIV_START(DIV_START), .DIV_SIGNED(DIV_SIGNED),
    .DIV_OPDATA1(DIV_OPDATA1), .DIV_OPDATA2(DIV_OPDATA2), .DIV_ANNUL(DIV_ANNUL),
    .DIV_RESULT(DIV_RESULT), .DIV_READY(DIV_READY), .DIV_BUSY(DIV_BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present operands at a negedge, let the START edge (E0) happen, then scramble the inputs.
  task automatic start_op(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    @(negedge CLK);
    DIV_SIGNED  = sgn;
    DIV_OPDATA1 = x;
    DIV_OPDATA2 = y;
    DIV_START   = 1'b1;
    @(posedge CLK);
    #1;
    DIV_OPDATA1 = 32'hDEAD_BEEF;
    DIV_OPDATA2 = 32'h0000_0001;
    DIV_SIGNED  = ~sgn;
  endtask

  // lat = index k of the first edge E_k after which READY is seen, or -1 on timeout.
  task automatic wait_ready(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DIV_READY === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drop_start();
    DIV_START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DIV_START = 1'b1;
    DIV_OPDATA1 = 32'd10;
    DIV_OPDATA2 = 32'd2;
    repeat (3) @(negedge CLK);
    checks++;
    if (DIV_READY !== 1'b0 || DIV_BUSY !== 1'b0 || DIV_RESULT !== 64'd0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b busy=%b result=%h required 0 0 0", DIV_READY, DIV_BUSY, DIV_RESULT);
    end
    DIV_START = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (DIV_READY !== 1'b0 || DIV_BUSY !== 1'b0 || DIV_RESULT !== 64'd0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b result=%h required 0 0 0", DIV_READY, DIV_BUSY, DIV_RESULT);
    end
  endtask

  task automatic test_divu_basic();
    int lat;
    start_op(1'b0, 32'd100, 32'd7);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL divu_latency: got %0d required 33", lat);
    end
    checks++;
    if (DIV_RESULT !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL divu_result: got %h required %h", DIV_RESULT, 64'h00000002_0000000E);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (DIV_READY !== 1'b1 || DIV_RESULT !== 64'h00000002_0000000E) begin
        errors++;
        $display("FAIL divu_hold: ready=%b result=%h required 1 %h", DIV_READY, DIV_RESULT, 64'h00000002_0000000E);
      end
    end
    drop_start();
    checks++;
    if (DIV_READY !== 1'b0 || DIV_RESULT !== 64'd0 || DIV_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL divu_release: ready=%b busy=%b result=%h required 0 0 0", DIV_READY, DIV_BUSY, DIV_RESULT);
    end
  endtask

  task automatic test_signed();
    int lat;
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33 || DIV_RESULT !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL div_neg7_by_2: lat=%0d result=%h required 33 %h", lat, DIV_RESULT, 64'hFFFFFFFF_FFFFFFFD);
    end
    drop_start();
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33 || DIV_RESULT !== 64'h00000001_FFFFFFFD) begin
      errors++;
      $display("FAIL div_7_by_neg2: lat=%0d result=%h required 33 %h", lat, DIV_RESULT, 64'h00000001_FFFFFFFD);
    end
    drop_start();
  endtask

  task automatic test_div_by_zero();
    @(negedge CLK);
    DIV_SIGNED = 1'b0;
    DIV_OPDATA1 = 32'd5;
    DIV_OPDATA2 = 32'd0;
    DIV_START = 1'b1;
    @(negedge CLK);
    checks++;
    if (DIV_BUSY !== 1'b1 || DIV_READY !== 1'b0) begin
      errors++;
      $display("FAIL divzero_e0: busy=%b ready=%b required 1 0", DIV_BUSY, DIV_READY);
    end
    @(negedge CLK);
    checks++;
    if (DIV_BUSY !== 1'b1 || DIV_READY !== 1'b1 || DIV_RESULT !== 64'd0) begin
      errors++;
      $display("FAIL divzero_e1: busy=%b ready=%b result=%h required 1 1 0", DIV_BUSY, DIV_READY, DIV_RESULT);
    end
    drop_start();
    checks++;
    if (DIV_BUSY !== 1'b0 || DIV_READY !== 1'b0) begin
      errors++;
      $display("FAIL divzero_release: busy=%b ready=%b required 0 0", DIV_BUSY, DIV_READY);
    end
  endtask

  task automatic test_overflow();
    int lat;
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33 || DIV_RESULT !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL div_overflow: lat=%0d result=%h required 33 %h", lat, DIV_RESULT, 64'h00000000_80000000);
    end
    drop_start();
    // Unsigned: 2147483648 / 4294967295 = 0 remainder 2147483648.
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33 || DIV_RESULT !== 64'h80000000_00000000) begin
      errors++;
      $display("FAIL divu_big: lat=%0d result=%h required 33 %h", lat, DIV_RESULT, 64'h80000000_00000000);
    end
    drop_start();
  endtask

  task automatic abort_then_9_by_3(input logic use_rst);
    int lat;
    int seen_ready;
    seen_ready = 0;
    start_op(1'b0, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (DIV_READY !== 1'b0) seen_ready++;
    end
    DIV_START = 1'b0;
    if (use_rst) RST = 1'b1;
    else DIV_ANNUL = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    DIV_ANNUL = 1'b0;
    checks++;
    if (seen_ready != 0 || DIV_BUSY !== 1'b0 || DIV_READY !== 1'b0 || DIV_RESULT !== 64'd0) begin
      errors++;
      $display("FAIL abort_rst%0b: early_ready=%0d busy=%b ready=%b result=%h required 0 0 0 0",
               use_rst, seen_ready, DIV_BUSY, DIV_READY, DIV_RESULT);
    end
    start_op(1'b0, 32'd9, 32'd3);
    wait_ready(40, lat);
    checks++;
    if (lat !== 33 || DIV_RESULT !== 64'h00000000_00000003) begin
      errors++;
      $display("FAIL after_abort_rst%0b: lat=%0d result=%h required 33 %h", use_rst, lat, DIV_RESULT, 64'h3);
    end
    drop_start();
  endtask

  task automatic test_annul();
    // Annul alongside START in FREE blocks acceptance.
    @(negedge CLK);
    DIV_SIGNED = 1'b0;
    DIV_OPDATA1 = 32'd50;
    DIV_OPDATA2 = 32'd5;
    DIV_START = 1'b1;
    DIV_ANNUL = 1'b1;
    @(negedge CLK);
    checks++;
    if (DIV_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL annul_in_free: busy=%b required 0", DIV_BUSY);
    end
    DIV_START = 1'b0;
    DIV_ANNUL = 1'b0;
    abort_then_9_by_3(1'b0);
  endtask

  task automatic test_rst_abort();
    abort_then_9_by_3(1'b1);
  endtask

  task automatic test_zero_dividend();
    int lat;
    int exp_lat;
`ifdef DIV_ZERO_DIVIDEND_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    start_op(1'b1, 32'd0, 32'd5);
    wait_ready(40, lat);
    checks++;
    if (lat !== exp_lat || DIV_RESULT !== 64'd0) begin
      errors++;
      $display("FAIL zero_dividend: lat=%0d result=%h required %0d 0", lat, DIV_RESULT, exp_lat);
    end
    drop_start();
  endtask

  initial begin
    RST = 1'b1;
    DIV_START = 1'b0;
    DIV_SIGNED = 1'b0;
    DIV_ANNUL = 1'b0;
    DIV_OPDATA1 = '0;
    DIV_OPDATA2 = '0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_annul();
    test_rst_abort();
    test_zero_dividend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
